char_glyph_sequencer: RTL and testbench

Sequences the 64x8 character glyph ROM (4 glyphs x 16 rows, 8 px wide, registered 1-cycle read) for one text scanline. Pulls glyph codes from the text buffer over a valid/ready handshake and drives the ROM address. Serialises each returned glyph row into a continuous MSB-first pixel stream. Sits between the text buffer and the VGA colour mux, in the pixelClk domain.

---
 rtl/char_glyph_sequencer_if.sv | 10 +
 rtl/char_glyph_sequencer.sv | 134 +++++++++++++
 tb/tb_char_glyph_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_glyph_sequencer_if.sv
// Glyph-code handshake between the text buffer (master) and the glyph sequencer (slave).
// The sequencer raises outCodeReady for one cycle per cell; the buffer answers with inCode/inCodeValid.
interface char_glyph_sequencer_if;
    logic [1:0] inCode;
    logic       inCodeValid;
    logic       outCodeReady;

    modport master (output inCode, output inCodeValid, input outCodeReady);
    modport slave  (input inCode, input inCodeValid, output outCodeReady);
endinterface

// File: rtl/char_glyph_sequencer.sv
// Glyph ROM sequencer: fetches one code per cell, drives the ROM address, serialises rows MSB first.
// Latency: first pixel 3 cycles after inLineStart, then 8*COLS gapless pixels.
// Backpressure: none; a fetch that finds inCodeValid low renders a blank cell and sets outUnderrun.
// Optional underline cursor: CHARSEQ_CURSOR_EN.
module char_glyph_sequencer #(
    parameter int COLS = 80
) (
    input  logic                          pixelClk,
    input  logic                          rstN,
    input  logic                          inLineStart,
    input  logic [3:0]                    inRow,
    char_glyph_sequencer_if.slave         codeIf,
    output logic [5:0]                    outRomAddr,
    input  logic [7:0]                    inRomData,
    output logic                          outPixel,
    output logic                          outPixelValid,
    output logic                          outLineDone,
    output logic                          outUnderrun,
    input  logic                          inUnderrunClr,
    input  logic [7:0]                    inCursorCol
);
    typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    state_t      state;
    logic [3:0]  row;
    logic [7:0]  fetchCol;
    logic [7:0]  dispCol;
    logic [2:0]  pixCnt;
    logic [7:0]  shReg;
    logic        st1, st2;
    logic        blank1, blank2;
    logic        cur1, cur2;
    logic        curHit;
    logic [7:0]  loadByte;

`ifdef CHARSEQ_CURSOR_EN
    assign curHit = (fetchCol == inCursorCol) && (row >= 4'hE);
`else
    logic unusedCursorCol;
    assign unusedCursorCol = ^inCursorCol;
    assign curHit = 1'b0;
`endif

    // Cursor overrides blanking so the underline shows even on an underrun cell.
    assign loadByte = cur2 ? 8'hFF : (blank2 ? 8'h00 : inRomData);
    assign outPixel = shReg[7];

    always_ff @(posedge pixelClk) begin
        if (!rstN) begin
            state               <= IDLE;
            row                 <= 4'h0;
            fetchCol            <= 8'h00;
            dispCol             <= 8'h00;
            pixCnt              <= 3'd0;
            shReg               <= 8'h00;
            st1                 <= 1'b0;
            st2                 <= 1'b0;
            blank1              <= 1'b0;
            blank2              <= 1'b0;
            cur1                <= 1'b0;
            cur2                <= 1'b0;
            codeIf.outCodeReady <= 1'b0;
            outRomAddr          <= 6'h00;
            outPixelValid       <= 1'b0;
            outLineDone         <= 1'b0;
            outUnderrun         <= 1'b0;
        end else begin
            // Two-stage tag pipeline tracks a fetch through the ROM read to its load edge.
            st1    <= 1'b0;
            st2    <= st1;
            blank2 <= blank1;
            cur2   <= cur1;

            if (codeIf.outCodeReady) begin
                codeIf.outCodeReady <= 1'b0;
                outRomAddr <= {(codeIf.inCodeValid ? codeIf.inCode : 2'b00), row};
                blank1     <= ~codeIf.inCodeValid;
                cur1       <= curHit;
                st1        <= 1'b1;
                fetchCol   <= fetchCol + 8'd1;
            end

            if (codeIf.outCodeReady && !codeIf.inCodeValid) begin
                outUnderrun <= 1'b1;
            end else if (inUnderrunClr) begin
                outUnderrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (inLineStart) begin
                        row                 <= inRow;
                        fetchCol            <= 8'h00;
                        dispCol             <= 8'h00;
                        codeIf.outCodeReady <= 1'b1;
                        state               <= FETCH;
                    end
                end
                FETCH: begin
                    if (st2) begin
                        shReg         <= loadByte;
                        pixCnt        <= 3'd0;
                        outPixelValid <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    if (outLineDone) begin
                        outLineDone   <= 1'b0;
                        outPixelValid <= 1'b0;
                        shReg         <= 8'h00;
                        state         <= IDLE;
                    end else begin
                        pixCnt <= pixCnt + 3'd1;
                        if (st2) begin
                            shReg   <= loadByte;
                            dispCol <= dispCol + 8'd1;
                        end else begin
                            shReg <= {shReg[6:0], 1'b0};
                        end
                        // Fetch issued at pixel 4 lands its byte exactly as pixel 7 retires.
                        if (pixCnt == 3'd4 && fetchCol <= LAST_COL) begin
                            codeIf.outCodeReady <= 1'b1;
                        end
                        outLineDone <= (pixCnt == 3'd6) && (dispCol == LAST_COL);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_char_glyph_sequencer.sv
// Randomised bench for char_glyph_sequencer: expected pixel stream built from ROM contents and cell codes.
module tb_char_glyph_sequencer;
    localparam int COLS = 3;
    localparam int LAST = 3 + 8 * COLS;

    logic       pixelClk = 1'b0;
    logic       rstN = 1'b0;
    logic       inLineStart = 1'b0;
    logic [3:0] inRow = 4'h0;
    logic [5:0] outRomAddr;
    logic [7:0] inRomData = 8'h00;
    logic       outPixel, outPixelValid, outLineDone, outUnderrun;
    logic       inUnderrunClr = 1'b0;
    logic [7:0] inCursorCol = 8'h00;

    char_glyph_sequencer_if codeIf ();

    char_glyph_sequencer #(.COLS(COLS)) dut (
        .pixelClk      (pixelClk),
        .rstN          (rstN),
        .inLineStart   (inLineStart),
        .inRow         (inRow),
        .codeIf        (codeIf.slave),
        .outRomAddr    (outRomAddr),
        .inRomData     (inRomData),
        .outPixel      (outPixel),
        .outPixelValid (outPixelValid),
        .outLineDone   (outLineDone),
        .outUnderrun   (outUnderrun),
        .inUnderrunClr (inUnderrunClr),
        .inCursorCol   (inCursorCol)
    );

    always #5 pixelClk = ~pixelClk;

    logic [7:0] rom [64];
    always @(posedge pixelClk) inRomData <= rom[outRomAddr];

    int         checks = 0;
    int         errors = 0;
    logic [1:0] codes [COLS];
    bit         vld [COLS];
    logic [3:0] lineRow;
    logic [7:0] cursorCol;
    bit         expUnd;

    // Runs one full line starting at #1 after an edge; ends at #1 after the first idle cycle's edge,
    // so consecutive calls start lines at the earliest accepted edge.
    task automatic runLine(input bit clrHold, input bit noise);
        logic [7:0] glyph [COLS];
        bit         expVld, expDone, expRdy, expPix;
        for (int c = 0; c < COLS; c++) begin
            glyph[c] = vld[c] ? rom[{codes[c], lineRow}] : 8'h00;
`ifdef CHARSEQ_CURSOR_EN
            if (c == int'(cursorCol) && lineRow >= 4'hE) glyph[c] = 8'hFF;
`endif
        end
        inRow = lineRow;
        inCursorCol = cursorCol;
        inUnderrunClr = clrHold;
        inLineStart = 1'b1;
        @(posedge pixelClk); #1;
        for (int n = 0; n <= LAST; n++) begin
            if (n == 0) begin
                if (clrHold) expUnd = 1'b0;
            end else if ((n - 1) % 8 == 0 && (n - 1) / 8 < COLS && !vld[(n - 1) / 8]) begin
                expUnd = 1'b1;
            end else if (clrHold) begin
                expUnd = 1'b0;
            end
            expVld  = (n >= 3) && (n < LAST);
            expDone = (n == LAST - 1);
            expRdy  = (n % 8 == 0) && (n / 8 < COLS);
            checks += 4;
            if (outPixelValid !== expVld) begin
                errors++; $display("FAIL pixvalid n=%0d got %b want %b", n, outPixelValid, expVld);
            end
            if (outLineDone !== expDone) begin
                errors++; $display("FAIL linedone n=%0d got %b want %b", n, outLineDone, expDone);
            end
            if (codeIf.outCodeReady !== expRdy) begin
                errors++; $display("FAIL codeready n=%0d got %b want %b", n, codeIf.outCodeReady, expRdy);
            end
            if (outUnderrun !== expUnd) begin
                errors++; $display("FAIL underrun n=%0d got %b want %b", n, outUnderrun, expUnd);
            end
            if (expVld) begin
                expPix = glyph[(n - 3) / 8][7 - ((n - 3) % 8)];
                checks++;
                if (outPixel !== expPix) begin
                    errors++; $display("FAIL pixel n=%0d got %b want %b", n, outPixel, expPix);
                end
            end
            if ((n - 1) % 8 == 0 && (n - 1) / 8 < COLS && n >= 1) begin
                checks++;
                if (outRomAddr !== {(vld[(n - 1) / 8] ? codes[(n - 1) / 8] : 2'b00), lineRow}) begin
                    errors++; $display("FAIL romaddr n=%0d got %h want %h", n, outRomAddr,
                                       {(vld[(n - 1) / 8] ? codes[(n - 1) / 8] : 2'b00), lineRow});
                end
            end
            if (n < LAST) begin
                if (n % 8 == 0 && n / 8 < COLS) begin
                    codeIf.inCode = codes[n / 8];
                    codeIf.inCodeValid = vld[n / 8];
                end else begin
                    codeIf.inCode = 2'($urandom);
                    codeIf.inCodeValid = 1'($urandom);
                end
                inLineStart = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
                inRow = 4'($urandom);
                @(posedge pixelClk); #1;
            end
        end
        inLineStart = 1'b0;
        inUnderrunClr = 1'b0;
        inRow = lineRow;
    endtask

    task automatic randomLine();
        for (int c = 0; c < COLS; c++) begin
            codes[c] = 2'($urandom);
            vld[c] = 1'b1;
        end
        lineRow = 4'($urandom);
        cursorCol = 8'($urandom_range(0, COLS));
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        codeIf.inCode = 2'b00;
        codeIf.inCodeValid = 1'b0;
        repeat (3) @(posedge pixelClk);
        #1;
        checks++;
        if ({codeIf.outCodeReady, outRomAddr, outPixel, outPixelValid, outLineDone, outUnderrun} !== 11'h000) begin
            errors++;
            $display("FAIL reset_values got rdy=%b addr=%h pix=%b vld=%b done=%b und=%b want all zero",
                     codeIf.outCodeReady, outRomAddr, outPixel, outPixelValid, outLineDone, outUnderrun);
        end
        rstN = 1'b1;
        expUnd = 1'b0;
        @(posedge pixelClk); #1;
    endtask

    task automatic test_basic();
        rom[6'h10] = 8'h1F;
        rom[6'h00] = 8'h00;
        codes[0] = 2'd1; codes[1] = 2'd0; codes[2] = 2'd0;
        vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
        lineRow = 4'h0;
        cursorCol = 8'd200;
        runLine(1'b0, 1'b0);
    endtask

    task automatic test_glyph_rows();
        rom[6'h13] = 8'hDF;
        rom[6'h23] = 8'hDF;
        codes[0] = 2'd1; codes[1] = 2'd2; codes[2] = 2'd1;
        vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
        lineRow = 4'h3;
        cursorCol = 8'd200;
        runLine(1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        randomLine();
        vld[1] = 1'b0;
        runLine(1'b0, 1'b0);
        @(posedge pixelClk); #1;
        checks++;
        if (outUnderrun !== 1'b1) begin
            errors++; $display("FAIL underrun_sticky got %b want 1", outUnderrun);
        end
        inUnderrunClr = 1'b1;
        @(posedge pixelClk); #1;
        inUnderrunClr = 1'b0;
        expUnd = 1'b0;
        checks++;
        if (outUnderrun !== 1'b0) begin
            errors++; $display("FAIL underrun_clear got %b want 0", outUnderrun);
        end
    endtask

    task automatic test_set_wins_clear();
        randomLine();
        vld[1] = 1'b0;
        vld[2] = 1'($urandom);
        runLine(1'b1, 1'b0);
    endtask

    task automatic test_ignore_linestart();
        for (int i = 0; i < 3; i++) begin
            randomLine();
            runLine(1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            randomLine();
            vld[$urandom_range(0, COLS - 1)] = 1'($urandom);
            runLine(1'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset_midline();
        @(posedge pixelClk); #1;
        inRow = 4'($urandom);
        codeIf.inCode = 2'($urandom);
        codeIf.inCodeValid = 1'b1;
        inLineStart = 1'b1;
        @(posedge pixelClk); #1;
        inLineStart = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge pixelClk); #1;
        end
        checks++;
        if (outPixelValid !== 1'b1) begin
            errors++; $display("FAIL midline_active got %b want 1", outPixelValid);
        end
        rstN = 1'b0;
        @(posedge pixelClk); #1;
        checks++;
        if ({codeIf.outCodeReady, outRomAddr, outPixel, outPixelValid, outLineDone, outUnderrun} !== 11'h000) begin
            errors++;
            $display("FAIL midline_reset got rdy=%b addr=%h pix=%b vld=%b done=%b und=%b want all zero",
                     codeIf.outCodeReady, outRomAddr, outPixel, outPixelValid, outLineDone, outUnderrun);
        end
        rstN = 1'b1;
        expUnd = 1'b0;
        randomLine();
        runLine(1'b0, 1'b0);
    endtask

    task automatic test_cursor();
        rom[6'h0E] = 8'($urandom);
        codes[0] = 2'd0; codes[1] = 2'd0; codes[2] = 2'd0;
        vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
        lineRow = 4'hE;
        cursorCol = 8'd1;
        runLine(1'b0, 1'b0);
        vld[1] = 1'b0;
        lineRow = 4'hF;
        runLine(1'b0, 1'b0);
        inUnderrunClr = 1'b1;
        @(posedge pixelClk); #1;
        inUnderrunClr = 1'b0;
        expUnd = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_glyph_rows();
        test_underrun();
        test_set_wins_clear();
        test_ignore_linestart();
        test_back_to_back();
        test_reset_midline();
        test_cursor();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
